// File: rtl/user_mm_pkg.sv
// Shared constants and types for the 4x4 matrix-multiply Wishbone slave.
package user_mm_pkg;

  localparam int          ELEM_W   = 8;
  localparam int          C_W      = 2 * ELEM_W + 2;
  localparam int          DIM      = 4;
  localparam int          N_ELEM   = DIM * DIM;
  localparam logic [11:0] BASE     = 12'h340;

  // Register offsets within the 256-byte window (adr[7:0]).
  localparam logic [7:0]  OFF_CTRL = 8'h00;
  localparam logic [7:0]  OFF_A    = 8'h40;
  localparam logic [7:0]  OFF_B    = 8'h80;
  localparam logic [7:0]  OFF_C    = 8'hC0;

  // Last loop index of the i/j/k counters.
  localparam logic [1:0]  LAST_IDX = 2'(DIM - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bank selector of an offset: 1 = A, 2 = B, 3 = C, 0 = control page.
  function automatic logic [1:0] bank_of(input logic [7:0] off);
    return off[7:6];
  endfunction

endpackage

// File: rtl/user_mm_mac.sv
// Multiply-accumulate unit: one unsigned product per enabled cycle.
// 'sum' is the running total including the current product; on the last
// term of a dot product the accumulator restarts from zero.
module user_mm_mac
  import user_mm_pkg::*;
#(
  parameter int W  = ELEM_W,
  parameter int AW = 2 * W + 2
) (
  input  logic          clk,
  input  logic          srst,
  input  logic          en,
  input  logic          clr,
  input  logic          last,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  output logic [AW-1:0] sum
);

  logic [AW-1:0]  acc_reg;
  logic [2*W-1:0] prod;

  assign prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
  assign sum  = acc_reg + AW'(prod);

  // Accumulator: cleared at reset/start, restarts after each completed dot product.
  always_ff @(posedge clk) begin
    if (srst || clr) begin
      acc_reg <= '0;
    end else if (en) begin
      acc_reg <= last ? '0 : sum;
    end
  end

endmodule

// File: rtl/user_mm_sched.sv
// Wishbone-attached 4x4 unsigned matrix multiplier: C = A * B.
// Operands are written over the bus, a start bit kicks off 64 MAC cycles,
// results land in a read-only C buffer and 'done' raises the interrupt.
module user_mm_sched
  import user_mm_pkg::*;
#(
  parameter logic [11:0] pBASE   = BASE,
  parameter int          pELEM_W = ELEM_W
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        irq_o
);

  localparam int CW = 2 * pELEM_W + 2;

  // Byte selects and the alias bits of the window are intentionally unused.
  logic unused_ok;
  assign unused_ok = ^{wbs_sel_i, wbs_adr_i[19:8], wbs_dat_i[31:pELEM_W]};

  // Operand and result storage.
  logic [pELEM_W-1:0] a_mem [N_ELEM];
  logic [pELEM_W-1:0] b_mem [N_ELEM];
  logic [CW-1:0]      c_mem [N_ELEM];

  // Bus state.
  logic        ack_reg;
  logic [31:0] dat_reg;
  logic [31:0] rdata;

  // Controller state.
  state_t     state_reg;
  logic       idle_reg;
  logic       done_reg;
  logic [1:0] i_reg;
  logic [1:0] j_reg;
  logic [1:0] k_reg;

  // Address decode.
  logic [7:0] off;
  logic [3:0] idx;
  logic       aligned;
  logic       valid;
  logic       xfer;
  logic       wr_fire;
  logic       rd_fire;
  logic       hit_ctrl;
  logic       hit_a;
  logic       hit_b;
  logic       hit_c;
  logic       start_fire;

  assign off        = wbs_adr_i[7:0];
  assign idx        = off[5:2];
  assign aligned    = (off[1:0] == 2'b00);
  assign valid      = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:20] == pBASE);
  assign xfer       = valid & ack_reg;
  assign wr_fire    = xfer & wbs_we_i;
  assign rd_fire    = xfer & ~wbs_we_i;
  assign hit_ctrl   = (off == OFF_CTRL);
  assign hit_a      = aligned & (bank_of(off) == bank_of(OFF_A));
  assign hit_b      = aligned & (bank_of(off) == bank_of(OFF_B));
  assign hit_c      = aligned & (bank_of(off) == bank_of(OFF_C));
  assign start_fire = wr_fire & hit_ctrl & wbs_dat_i[0] & (state_reg == ST_IDLE);

  // MAC datapath: operand fetch straight from the buffers by loop indices.
  logic          mac_en;
  logic          mac_last;
  logic [CW-1:0] mac_sum;

  assign mac_en   = (state_reg == ST_CALC);
  assign mac_last = (k_reg == LAST_IDX);

  user_mm_mac #(
    .W  (pELEM_W),
    .AW (CW)
  ) u_mac (
    .clk  (wb_clk_i),
    .srst (wb_rst_i),
    .en   (mac_en),
    .clr  (start_fire),
    .last (mac_last),
    .a    (a_mem[{i_reg, k_reg}]),
    .b    (b_mem[{k_reg, j_reg}]),
    .sum  (mac_sum)
  );

  // Zero-extended read views of every element.
  logic [31:0] a_rd [N_ELEM];
  logic [31:0] b_rd [N_ELEM];
  logic [31:0] c_rd [N_ELEM];

  generate
    for (genvar gi = 0; gi < N_ELEM; gi++) begin : g_rd
      assign a_rd[gi] = 32'(a_mem[gi]);
      assign b_rd[gi] = 32'(b_mem[gi]);
      assign c_rd[gi] = 32'(c_mem[gi]);
    end
  endgenerate

  // Read multiplexer; unmapped offsets read as zero.
  always_comb begin
    rdata = '0;
    if (hit_ctrl) begin
      rdata = {29'd0, idle_reg, done_reg, 1'b0};
    end else if (hit_a) begin
      rdata = a_rd[idx];
    end else if (hit_b) begin
      rdata = b_rd[idx];
    end else if (hit_c) begin
      rdata = c_rd[idx];
    end
  end

  // Bus handshake: one-cycle ack pulse, read data registered alongside it.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_reg <= 1'b0;
      dat_reg <= '0;
    end else begin
      ack_reg <= valid & ~ack_reg;
      dat_reg <= (valid & ~ack_reg & ~wbs_we_i) ? rdata : '0;
    end
  end

  // Sequencer: IDLE -> CALC (64 MACs over i,j,k) -> DONE -> IDLE.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_reg <= ST_IDLE;
      idle_reg  <= 1'b1;
      done_reg  <= 1'b0;
      i_reg     <= '0;
      j_reg     <= '0;
      k_reg     <= '0;
    end else begin
      // Reading the control word clears done; DONE below overrides it.
      if (rd_fire && hit_ctrl) begin
        done_reg <= 1'b0;
      end
      case (state_reg)
        ST_IDLE: begin
          if (start_fire) begin
            state_reg <= ST_CALC;
            idle_reg  <= 1'b0;
            i_reg     <= '0;
            j_reg     <= '0;
            k_reg     <= '0;
          end
        end
        ST_CALC: begin
          k_reg <= k_reg + 2'd1;
          if (k_reg == LAST_IDX) begin
            j_reg <= j_reg + 2'd1;
            if (j_reg == LAST_IDX) begin
              i_reg <= i_reg + 2'd1;
              if (i_reg == LAST_IDX) begin
                state_reg <= ST_DONE;
              end
            end
          end
        end
        ST_DONE: begin
          done_reg  <= 1'b1;
          idle_reg  <= 1'b1;
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // Buffers: operands writable only while idle, C written at each dot-product end.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int n = 0; n < N_ELEM; n++) begin
        a_mem[n] <= '0;
        b_mem[n] <= '0;
        c_mem[n] <= '0;
      end
    end else begin
      if (wr_fire && (state_reg == ST_IDLE)) begin
        if (hit_a) begin
          a_mem[idx] <= wbs_dat_i[pELEM_W-1:0];
        end
        if (hit_b) begin
          b_mem[idx] <= wbs_dat_i[pELEM_W-1:0];
        end
      end
      if (mac_en && mac_last) begin
        c_mem[{i_reg, j_reg}] <= mac_sum;
      end
    end
  end

  assign wbs_ack_o = ack_reg;
  assign wbs_dat_o = dat_reg;
  assign irq_o     = done_reg;

endmodule

// File: tb/tb_user_mm_sched.sv
// Directed bench for user_mm_sched with a cycle-level reference model.
module tb_user_mm_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb = 1'b0;
  logic        cyc = 1'b0;
  logic        we  = 1'b0;
  logic [3:0]  sel = 4'hF;
  logic [31:0] adr = '0;
  logic [31:0] dat_i = '0;
  logic        ack;
  logic [31:0] dat_o;
  logic        irq;

  user_mm_sched dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs_stb_i (stb),
    .wbs_cyc_i (cyc),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (dat_i),
    .wbs_ack_o (ack),
    .wbs_dat_o (dat_o),
    .irq_o     (irq)
  );

  always #5 clk = ~clk;

  // Posedge counter: register values observed at a negedge are those after edge edge_cnt.
  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  // Reference model: operand shadows, expected results, and event edges.
  int a_m [16];
  int b_m [16];
  int c_m [16];
  int st_edge  = -1;
  int set_edge = -1;
  int clr_edge = -1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
  endtask

  function automatic bit m_idle(input int e);
    return !(st_edge >= 0 && e >= st_edge && e <= st_edge + 64);
  endfunction

  function automatic bit m_done(input int e);
    return (set_edge >= 0) && (e >= set_edge) && !(clr_edge > set_edge && clr_edge <= e);
  endfunction

  task automatic model_reset();
    for (int n = 0; n < 16; n++) begin
      a_m[n] = 0; b_m[n] = 0; c_m[n] = 0;
    end
    st_edge = -1; set_edge = -1; clr_edge = -1;
  endtask

  task automatic model_compute();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        int s;
        s = 0;
        for (int k = 0; k < 4; k++) s += a_m[4*i+k] * b_m[4*k+j];
        c_m[4*i+j] = s;
      end
  endtask

  // Per-cycle comparison of the interrupt and the idle data bus.
  always @(negedge clk) begin
    if (chk_en) begin
      check("irq", {31'd0, irq}, {31'd0, m_done(edge_cnt)});
      if (!ack) check("dat_when_no_ack", dat_o, 32'd0);
    end
  end

  // One Wishbone classic transfer; p2 is the index of the completing edge.
  task automatic wb_xfer(input bit w, input logic [7:0] off, input logic [31:0] din,
                         output logic [31:0] dout, output int p2);
    int n;
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = w;
    adr = {12'h340, 12'h000, off};
    dat_i = din;
    n = 0;
    while (ack !== 1'b1 && n < 16) begin
      @(negedge clk);
      n++;
    end
    check("ack_seen", {31'd0, ack}, 32'd1);
    dout = dat_o;
    @(posedge clk);
    #1;
    p2 = edge_cnt;
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  task automatic wb_write(input logic [7:0] off, input logic [31:0] din);
    logic [31:0] dummy;
    int p2;
    wb_xfer(1'b1, off, din, dummy, p2);
    $display("wr off=0x%02h dat=0x%08h edge=%0d", off, din, p2);
    if (m_idle(p2 - 1)) begin
      if (off == 8'h00 && din[0]) begin
        st_edge = p2; set_edge = p2 + 65; clr_edge = -1;
        model_compute();
      end else if (off[7:6] == 2'b01 && off[1:0] == 2'b00) begin
        a_m[off[5:2]] = int'(din[7:0]);
      end else if (off[7:6] == 2'b10 && off[1:0] == 2'b00) begin
        b_m[off[5:2]] = int'(din[7:0]);
      end
    end
  endtask

  task automatic wb_read(input logic [7:0] off, output logic [31:0] dout, output int p2);
    logic [31:0] exp;
    wb_xfer(1'b0, off, 32'd0, dout, p2);
    exp = 32'd0;
    if (off == 8'h00) begin
      exp = {29'd0, m_idle(p2 - 2), m_done(p2 - 2), 1'b0};
      clr_edge = p2;
    end else if (off[1:0] == 2'b00) begin
      case (off[7:6])
        2'b01:   exp = 32'(a_m[off[5:2]]);
        2'b10:   exp = 32'(b_m[off[5:2]]);
        2'b11:   exp = 32'(c_m[off[5:2]]);
        default: exp = 32'd0;
      endcase
    end
    $display("rd off=0x%02h dat=0x%08h exp=0x%08h edge=%0d", off, dout, exp, p2);
    check("read", dout, exp);
  endtask

  task automatic read_all_c();
    logic [31:0] d;
    int p2;
    for (int n = 0; n < 16; n++) wb_read(8'(8'hC0 + 4*n), d, p2);
  endtask

  task automatic load_pattern1();
    for (int n = 0; n < 16; n++) begin
      wb_write(8'(8'h40 + 4*n), 32'(n % 4));
      wb_write(8'(8'h80 + 4*n), 32'(n + 1));
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (irq !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("done_wait", {31'd0, irq}, 32'd1);
  endtask

  task automatic apply_reset(input int cycles);
    @(negedge clk);
    chk_en = 1'b0;
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
  endtask

  initial begin
    logic [31:0] d;
    int p2;
    int ps;

    // Reset state
    apply_reset(3);
    wb_read(8'h00, d, p2);
    check("reset_ctrl", d, 32'h4);
    check("reset_irq", {31'd0, irq}, 32'd0);
    wb_read(8'hC0, d, p2);
    check("reset_c0", d, 32'd0);
    wb_read(8'hFC, d, p2);
    check("reset_c15", d, 32'd0);

    // Unmapped offsets, unaligned access, C write ignored
    wb_write(8'h10, 32'hDEAD_BEEF);
    wb_read(8'h10, d, p2);
    check("unmapped_zero", d, 32'd0);
    wb_read(8'h41, d, p2);
    wb_write(8'hC0, 32'd123);
    wb_read(8'hC0, d, p2);
    check("c_write_ignored", d, 32'd0);

    // Outside the region: never acknowledged
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 32'h3000_0000;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      check("no_ack_outside", {31'd0, ack}, 32'd0);
    end
    stb = 1'b0; cyc = 1'b0;

    // Basic product with exact completion timing
    load_pattern1();
    wb_read(8'h44, d, p2);
    wb_write(8'h00, 32'h1);
    ps = edge_cnt;
    while (edge_cnt < ps + 64) @(negedge clk);
    check("irq_low_at_64", {31'd0, irq}, 32'd0);
    @(negedge clk);
    check("irq_high_at_65", {31'd0, irq}, 32'd1);
    for (int j = 0; j < 4; j++) check("model_row0", 32'(c_m[j]), 32'(62 + 6*j));
    check("model_row3", 32'(c_m[15]), 32'd80);
    wb_read(8'h00, d, p2);
    check("ctrl_done", d, 32'h6);
    wb_read(8'h00, d, p2);
    check("ctrl_cleared", d, 32'h4);
    check("irq_cleared", {31'd0, irq}, 32'd0);
    read_all_c();
    wb_read(8'hD4, d, p2);
    check("c5_literal", d, 32'd68);

    // Writes during CALC are acknowledged but ignored
    wb_write(8'h00, 32'h1);
    wb_write(8'h80, 32'h55);
    wb_write(8'h00, 32'h1);
    wb_read(8'hC4, d, p2);
    wait_done();
    wb_read(8'h00, d, p2);
    check("ctrl_done2", d, 32'h6);
    read_all_c();
    wb_read(8'h80, d, p2);
    check("b0_frozen", d, 32'd1);
    wb_read(8'hFC, d, p2);
    check("c15_literal", d, 32'd80);

    // Largest operands: no truncation
    for (int n = 0; n < 16; n++) begin
      wb_write(8'(8'h40 + 4*n), 32'd255);
      wb_write(8'(8'h80 + 4*n), 32'd255);
    end
    wb_write(8'h00, 32'h1);
    wait_done();
    wb_read(8'h00, d, p2);
    check("model_max", 32'(c_m[5]), 32'h3F804);
    read_all_c();
    wb_read(8'hC8, d, p2);
    check("c_max_literal", d, 32'h3F804);

    // Reset at CALC cycle 20 aborts the run
    wb_write(8'h00, 32'h1);
    ps = edge_cnt;
    while (edge_cnt < ps + 19) @(negedge clk);
    apply_reset(1);
    wb_read(8'h00, d, p2);
    check("abort_ctrl", d, 32'h4);
    read_all_c();
    wb_read(8'hC0, d, p2);
    check("abort_c0", d, 32'd0);
    load_pattern1();
    wb_write(8'h00, 32'h1);
    wait_done();
    wb_read(8'h00, d, p2);
    read_all_c();
    wb_read(8'hCC, d, p2);
    check("rerun_c3", d, 32'd80);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/user_mm_sched.md
USER_MM_SCHED -- requirements
Module: user_mm_sched

Interface
REQ-001 pBASE, 12'h340, adr[31:20] match value selecting this block.
REQ-002 pELEM_W, 8, A/B element width; C width fixed at 2*pELEM_W+2 (18).
REQ-003 wb_clk_i  in  1  sole clock; all logic on rising edge.
REQ-004 wb_rst_i  in  1  reset, synchronous, active-high.
REQ-005 wbs_stb_i / wbs_cyc_i / wbs_we_i  in  1 each  Wishbone classic strobe, cycle, write-enable.
REQ-006 wbs_sel_i  in  4  byte selects; ignored, full-word access assumed.
REQ-007 wbs_adr_i  in  32  byte address; wbs_dat_i  in  32  write data.
REQ-008 wbs_ack_o  out  1  registered acknowledge; wbs_dat_o  out  32  read data.
REQ-009 irq_o  out  1  level interrupt, equals ap_ctrl.done.

Function
REQ-010 valid = stb & cyc & adr[31:20]==pBASE; no ack when adr outside pBASE region.
REQ-011 Ack: registered, high one cycle after valid seen with ack low; one-cycle pulse; transfer completes on edge where valid & ack.
REQ-012 Map (offset adr[7:0]): 0x00 ap_ctrl; 0x40-0x7C A[0..15]; 0x80-0xBC B[0..15]; 0xC0-0xFC C[0..15] read-only; element n at base+4n, data in low bits, upper bits read 0.
REQ-013 ap_ctrl: bit0 start (W1, reads 0), bit1 done (R, clear-on-read), bit2 idle (R), others 0.
REQ-014 Unmapped offsets inside region: acked, read 0, write ignored; writes to C acked, ignored.
REQ-015 FSM states IDLE, CALC, DONE; reset -> IDLE.
REQ-016 IDLE -> CALC on completing write to 0x00 with dat[0]=1; same edge: i=j=k=0, acc=0, idle=0.
REQ-017 CALC: one MAC per cycle, acc += A[4i+k]*B[4k+j]; k==3: C[4i+j] <= acc+product, acc <= 0, k wraps, j++ (j wrap -> i++).
REQ-018 CALC lasts exactly 64 cycles; after (3,3,3) -> DONE; DONE one cycle: done=1, idle=1 -> IDLE; idle reads 1 from cycle 65 after start edge.
REQ-019 Arithmetic unsigned, no overflow: max 4*255*255=260100 fits 18 bits.
REQ-020 Start write during CALC/DONE: acked, ignored.
REQ-021 A/B writes during CALC/DONE: acked, ignored (operands frozen).
REQ-022 C reads during CALC: return current buffer (previous results until overwritten).
REQ-023 done cleared on completing read of 0x00; if DONE sets it on same edge, set wins.
REQ-024 Read data valid in the ack cycle, 0 when ack low.

Reset
REQ-025 On wb_rst_i: state IDLE, idle=1, done=0, irq_o=0, wbs_ack_o=0, wbs_dat_o=0, A/B/C all 0, counters and acc 0.
REQ-026 Reset mid-CALC aborts immediately; no partial C retained; next start behaves as from power-up.

Structure
REQ-027 Package user_mm_pkg: FSM state encoding, register offsets, pELEM_W, C width, matrix dimension 4.
REQ-028 Sub-module user_mm_mac: 8x8 multiply + 18-bit accumulate with clear and last-term flag; controller owns counters, buffers, bus.

Verification
REQ-029 Reset -> read 0x00 = 0x4, irq_o=0, any C read = 0.
REQ-030 A rows {0,1,2,3}, B[n]=n+1, start -> C row = {62,68,74,80} every row; idle at cycle 65; done=1, irq_o=1.
REQ-031 A=B=all 255, start -> every C = 260100 (0x3F804), no truncation.
REQ-032 Read 0x00 after done -> 0x6 returned, next read 0x4, irq_o low.
REQ-033 During CALC write B[0]=0x55 and start=1 -> both acked, results unchanged vs REQ-030, B[0] reads old value.
REQ-034 Assert wb_rst_i at CALC cycle 20 -> IDLE, all C 0; fresh start yields REQ-030 results after reloading A/B.
